// File: rtl/replay_pkg.sv
// Shared definitions for both ends of the replay-protected serial link.
package replay_pkg;

  localparam int          REPLAY_FRAME_LEN = 8;
  localparam logic [7:0]  REPLAY_TAG_MAX   = 8'hFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    WAIT     = 3'd2,
    TAG      = 3'd3,
    TAG_WAIT = 3'd4
  } replay_state_e;

endpackage

// File: rtl/replay_tag_counter.sv
// Saturating replay-tag counter; once it reaches the maximum it holds there until reset.
module replay_tag_counter
  import replay_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [TAG_W-1:0] cnt_o,
  output logic             sat_o
);

  localparam logic [TAG_W-1:0] TAG_MAX = TAG_W'(REPLAY_TAG_MAX);

  logic [TAG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != TAG_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == TAG_MAX);

endmodule

// File: rtl/replay_protection_tx.sv
// Transmit-side replay-tag inserter: forwards payload bytes to the UART and
// appends a non-decreasing tag byte after every FRAME_LEN payload bytes.
module replay_protection_tx
  import replay_pkg::*;
#(
  parameter int FRAME_LEN = REPLAY_FRAME_LEN,
  parameter int TAG_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_complete,
  output logic       tag_sent,
  output logic       replay_exhausted
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  replay_state_e    state_q, state_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tag_inc;
  logic [TAG_W-1:0] tag_cnt;
  logic             tag_sat;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    tx_data_d  = tx_data_q;
    tag_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_valid) begin
          tx_data_d = data_in;
          state_d   = LOAD;
        end
      end
      LOAD: state_d = WAIT;
      WAIT: begin
        if (tx_complete) begin
          if (byte_idx_q == LAST_IDX) begin
            byte_idx_d = '0;
            tx_data_d  = 8'(tag_cnt);
            state_d    = TAG;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = IDLE;
          end
        end
      end
      TAG: state_d = TAG_WAIT;
      TAG_WAIT: begin
        if (tx_complete) begin
          tag_inc = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The in-flight byte is simply dropped on reset; the receiver resets with us.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      tx_data_q  <= tx_data_d;
    end
  end

  replay_tag_counter #(
    .TAG_W (TAG_W)
  ) u_tag_counter (
    .clk   (clk),
    .reset (reset),
    .inc_i (tag_inc),
    .cnt_o (tag_cnt),
    .sat_o (tag_sat)
  );

  assign data_ready       = (state_q == IDLE) && !reset;
  assign tx_start         = (state_q == LOAD) || (state_q == TAG);
  assign tx_data          = tx_data_q;
  assign tag_sent         = tag_inc;
  assign replay_exhausted = tag_sat;

endmodule

// File: tb/tb_replay_protection_tx.sv
// Scoreboard bench for replay_protection_tx with a UART responder and a
// receive-side replay checker model.
module tb_replay_protection_tx;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_complete;
  logic       tag_sent;
  logic       replay_exhausted;

  replay_protection_tx dut (
    .clk              (clk),
    .reset            (reset),
    .data_in          (data_in),
    .data_valid       (data_valid),
    .data_ready       (data_ready),
    .tx_data          (tx_data),
    .tx_start         (tx_start),
    .tx_complete      (tx_complete),
    .tag_sent         (tag_sent),
    .replay_exhausted (replay_exhausted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         fb = 0;
  int         frame_no = 0;
  int         tags_done = 0;
  int         uart_delay = 10;
  bit         uart_en = 1'b0;
  bit         busy = 1'b0;
  int         cnt = 0;
  logic [7:0] cur_byte = 8'h00;
  int         rx_pos = 0;
  int         rx_last = 0;
  bit         rx_error = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rx_feed(input logic [7:0] b);
    rx_pos++;
    if (rx_pos == 9) begin
      if (int'(b) < rx_last) rx_error = 1'b1;
      rx_last = int'(b);
      rx_pos  = 0;
    end
  endtask

  // UART transmitter model: accepts tx_start, returns tx_complete after uart_delay cycles.
  initial begin
    tx_complete = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_en) begin
        tx_complete = 1'b0;
        if (busy) begin
          if (tx_start) chk("tx_start_pulse", 32'(tx_start), 32'd0);
          cnt--;
          if (cnt == 0) begin
            chk("tx_data_hold", 32'(tx_data), 32'(cur_byte));
            tx_complete = 1'b1;
            busy        = 1'b0;
          end
        end else if (tx_start) begin
          cur_byte = tx_data;
          if (exp_q.size() == 0) chk("sb_unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
          else chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
          rx_feed(tx_data);
          busy = 1'b1;
          cnt  = uart_delay;
        end
        #1;
        if (tag_sent) begin
          chk("exhausted_at_tag", 32'(replay_exhausted), 32'(tags_done >= 255));
          tags_done++;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    uart_en    = 1'b0;
    data_valid = 1'b0;
    reset      = 1'b1;
    #1;
    chk("rst_ready_in_reset", 32'(data_ready), 32'd0);
    @(negedge clk);
    reset       = 1'b0;
    tx_complete = 1'b0;
    busy        = 1'b0;
    cnt         = 0;
    exp_q.delete();
    fb        = 0;
    frame_no  = 0;
    tags_done = 0;
    rx_pos    = 0;
    rx_last   = 0;
    #1;
    chk("rst_ready", 32'(data_ready), 32'd1);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tag_sent", 32'(tag_sent), 32'd0);
    chk("rst_exhausted", 32'(replay_exhausted), 32'd0);
    uart_en = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    data_in    = b;
    data_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (data_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("send_timeout", 32'd0, 32'd1);
      data_valid = 1'b0;
      return;
    end
    exp_q.push_back(b);
    fb++;
    if (fb == 8) begin
      exp_q.push_back((frame_no >= 255) ? 8'hFF : 8'(frame_no));
      frame_no++;
      fb = 0;
    end
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 5000; k++) begin
      if (exp_q.size() == 0 && !busy) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("drain_done", 32'(exp_q.size() == 0 && !busy), 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    data_in    = 8'h00;
    data_valid = 1'b0;

    // Single frame with a slow UART
    do_reset();
    uart_delay = 10;
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    drain();
    chk("t1_tag_sent_cnt", 32'(tags_done), 32'd1);

    // Three back-to-back frames
    do_reset();
    uart_delay = 4;
    for (int i = 0; i < 24; i++) send_byte(8'($urandom_range(0, 255)));
    drain();
    chk("t2_tag_sent_cnt", 32'(tags_done), 32'd3);
    chk("t2_replay_error", 32'(rx_error), 32'd0);

    // Ignored data_valid in WAIT and spurious tx_complete in LOAD
    do_reset();
    uart_en = 1'b0;
    @(negedge clk);
    data_in    = 8'hA5;
    data_valid = 1'b1;
    #1;
    chk("t3_ready_idle", 32'(data_ready), 32'd1);
    @(negedge clk);
    data_in     = 8'h3C;
    tx_complete = 1'b1;
    #1;
    chk("t3_load_start", 32'(tx_start), 32'd1);
    chk("t3_load_data", 32'(tx_data), 32'hA5);
    chk("t3_load_ready", 32'(data_ready), 32'd0);
    @(negedge clk);
    tx_complete = 1'b0;
    #1;
    chk("t3_wait_start", 32'(tx_start), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("t3_wait_ready", 32'(data_ready), 32'd0);
      chk("t3_wait_hold", 32'(tx_data), 32'hA5);
    end
    @(negedge clk);
    data_valid  = 1'b0;
    tx_complete = 1'b1;
    @(negedge clk);
    tx_complete = 1'b0;
    #1;
    chk("t3_back_idle", 32'(data_ready), 32'd1);
    fb      = 1;
    rx_pos  = 1;
    uart_en = 1'b1;
    uart_delay = 3;
    for (int i = 0; i < 7; i++) send_byte(8'h50 + 8'(i));
    drain();
    chk("t3_tag_sent_cnt", 32'(tags_done), 32'd1);

    // Tag counter saturation over 257 frames
    do_reset();
    uart_delay = 3;
    rx_error   = 1'b0;
    for (int i = 0; i < 257 * 8; i++) send_byte(8'(i));
    drain();
    chk("t4_tag_sent_cnt", 32'(tags_done), 32'd257);
    chk("t4_exhausted", 32'(replay_exhausted), 32'd1);
    chk("t4_replay_error", 32'(rx_error), 32'd0);

    // Reset mid-frame, then a fresh frame starting at tag 00
    do_reset();
    uart_delay = 5;
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i));
    do_reset();
    rx_error = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'hE0 + 8'(i));
    drain();
    chk("t5_tag_sent_cnt", 32'(tags_done), 32'd1);
    chk("t5_replay_error", 32'(rx_error), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
